// File: rtl/mandel_pkg.sv
// mandel_pkg: shared types and constants for the Mandelbrot result path
package mandel_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [2:0] {IDLE, SYNC, ROW, PIX, CSUM} state_e;
    localparam byte_t SYNC_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/mandel_tx_framer_fifo.sv
// pixel_fifo: first-word-fall-through FIFO buffering pixel counts ahead of the framer
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];
    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
    // Pointers move independently, so a simultaneous push and pop keeps occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) wptr_q <= wptr_q + 1'b1;
            if (pop && !empty) rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/mandel_tx_framer.sv
// mandel_tx_framer: packs pixel counts into SYNC/row/pixels/checksum frames for uart_tx
module mandel_tx_framer
    import mandel_pkg::*;
#(
    parameter int    NC         = 8,
    parameter int    BLOCK_SIZE = 64,
    parameter int    FIFO_DEPTH = 16,
    parameter byte_t SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [NC-1:0] pix_count,
    output logic          pix_ready,
    output byte_t         tx_data,
    output logic          tx_start,
    input  logic          tx_active,
    output logic          busy,
    output logic          done
);
    localparam int            TOTAL    = BLOCK_SIZE * BLOCK_SIZE;
    localparam int            PW       = $clog2(BLOCK_SIZE);
    localparam int            AW       = $clog2(TOTAL + 1);
    localparam byte_t         LAST_ROW = byte_t'(BLOCK_SIZE - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(BLOCK_SIZE - 1);

    state_e        state_q;
    byte_t         row_q, csum_q, tx_data_q, fifo_rdata;
    logic [PW-1:0] pix_q;
    logic [AW-1:0] acc_q;
    logic          busy_q, tx_start_q, done_q, last_q;
    logic          fifo_full, fifo_empty, push, pop, can_issue;

    // uart_tx raises tx_active one cycle late, so the issue pulse itself guards the next cycle
    assign can_issue = !tx_active && !tx_start_q;
    assign pix_ready = busy_q && !fifo_full && (acc_q < AW'(TOTAL));
    assign push      = pix_valid && pix_ready;
    assign pop       = (state_q == PIX) && can_issue && !fifo_empty;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign busy      = busy_q;
    assign done      = done_q;

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (8'(pix_count)),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_rdata)
    );

    // Frame sequencer: one byte per issue slot; done/busy settle the cycle after the final byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            pix_q      <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= last_q;
            last_q     <= 1'b0;
            if (last_q) busy_q <= 1'b0;
            if (push) acc_q <= acc_q + 1'b1;
            case (state_q)
                IDLE: if (start && !busy_q) begin
                    busy_q  <= 1'b1;
                    row_q   <= '0;
                    pix_q   <= '0;
                    acc_q   <= '0;
                    state_q <= SYNC;
                end
                SYNC: if (can_issue) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= SYNC_BYTE;
                    csum_q     <= '0;
                    state_q    <= ROW;
                end
                ROW: if (can_issue) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= row_q;
                    csum_q     <= csum_q ^ row_q;
                    state_q    <= PIX;
                end
                PIX: if (pop) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= fifo_rdata;
                    csum_q     <= csum_q ^ fifo_rdata;
                    pix_q      <= (pix_q == LAST_PIX) ? '0 : pix_q + 1'b1;
                    state_q    <= (pix_q == LAST_PIX) ? CSUM : PIX;
                end
                CSUM: if (can_issue) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= csum_q;
                    last_q     <= (row_q == LAST_ROW);
                    row_q      <= (row_q == LAST_ROW) ? row_q : row_q + 1'b1;
                    state_q    <= (row_q == LAST_ROW) ? IDLE : SYNC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mandel_tx_framer.sv
// tb_mandel_tx_framer: directed checks of framing, stalls, back-pressure, reset abort and truncation
module tb_mandel_tx_framer;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0, hold_act = 1'b0;
    logic [9:0] pix_count = '0;
    logic       pix_ready, tx_start, tx_active, busy, done;
    logic [7:0] tx_data;
    int         act_cnt = 0, nvec = 0, nerr = 0, done_cnt = 0, done_at = -1;
    logic [7:0] bytes[$], exp_q[$];
    logic [9:0] acc_log[$];
    logic [9:0] px [16];
    logic [7:0] row0_hand [7] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    logic [7:0] row1_hand [7] = '{8'hA5, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D};

    always #5 clk = ~clk;

    mandel_tx_framer #(.NC(10), .BLOCK_SIZE(4), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_count (pix_count),
        .pix_ready (pix_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_active (tx_active),
        .busy      (busy),
        .done      (done)
    );

    assign tx_active = hold_act || (act_cnt != 0);

    always @(posedge clk) begin
        if (done) begin
            done_cnt++;
            done_at = bytes.size();
        end
        if (tx_start) bytes.push_back(tx_data);
        if (pix_valid && pix_ready) acc_log.push_back(pix_count);
        act_cnt <= tx_start ? 3 : (act_cnt != 0 ? act_cnt - 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] got(input int i);
        return (i < bytes.size()) ? 32'(bytes[i]) : 32'hDEAD;
    endfunction

    task automatic clear_logs();
        bytes.delete();
        acc_log.delete();
        done_cnt = 0;
        done_at  = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_pix(input logic [9:0] v);
        int t = 0;
        pix_valid = 1'b1;
        pix_count = v;
        while (!pix_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (bytes.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_bytes_%0d", n), 32'(bytes.size() >= n), 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
    endtask

    task automatic build_exp();
        logic [7:0] cs, b;
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin
            cs = 8'(r);
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(r));
            for (int c = 0; c < 4; c++) begin
                b = px[4*r+c][7:0];
                exp_q.push_back(b);
                cs ^= b;
            end
            exp_q.push_back(cs);
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, bytes.size(), exp_q.size());
        foreach (exp_q[i]) chk($sformatf("%s_b%0d", tag, i), got(i), 32'(exp_q[i]));
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_done_after_last"}, done_at, 28);
        chk({tag, "_accepts"}, acc_log.size(), 16);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // plain block, pixels 1..16
        clear_logs();
        for (int i = 0; i < 16; i++) px[i] = 10'(i + 1);
        pulse_start();
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_first_tx_start", tx_start, 1);
        chk("t1_first_tx_data", tx_data, 8'hA5);
        for (int i = 0; i < 16; i++) push_pix(px[i]);
        wait_done();
        chk("t1_busy_low", busy, 0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) chk($sformatf("t1_row0_%0d", i), got(i), 32'(row0_hand[i]));
        for (int i = 0; i < 7; i++) chk($sformatf("t1_row1_%0d", i), got(7 + i), 32'(row1_hand[i]));
        build_exp();
        check_stream("t1");

        // engine stall in the middle of row 1
        clear_logs();
        pulse_start();
        for (int i = 0; i < 6; i++) push_pix(px[i]);
        wait_bytes(11);
        n0 = bytes.size();
        chk("t2_starved_at", n0, 11);
        repeat (50) @(negedge clk);
        chk("t2_no_tx_in_stall", bytes.size(), n0);
        for (int i = 6; i < 16; i++) push_pix(px[i]);
        wait_done();
        repeat (10) @(negedge clk);
        check_stream("t2");

        // back-pressure, start while busy, and a 17th pixel on offer
        clear_logs();
        hold_act = 1'b1;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            pix_valid = 1'b1;
            pix_count = 10'(100 + acc_log.size());
            start = (c == 50);
            @(negedge clk);
        end
        start = 1'b0;
        chk("t3_accepts_at_ready_fall", acc_log.size(), 16);
        chk("t3_ready_low", pix_ready, 0);
        chk("t3_no_tx_while_held", bytes.size(), 0);
        hold_act = 1'b0;
        wait_done();
        pix_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_idle_after", busy, 0);
        for (int i = 0; i < 16; i++) px[i] = 10'(100 + i);
        build_exp();
        check_stream("t3");

        // reset in the middle of PIX
        clear_logs();
        hold_act = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) push_pix(10'(i + 1));
        hold_act = 1'b0;
        wait_bytes(4);
        chk("t4_in_pix", 32'(bytes.size() < 7), 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_pix_ready", pix_ready, 0);
        chk("t4_rst_tx_data", tx_data, 0);
        chk("t4_rst_tx_start", tx_start, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fresh block after abort, with 10-bit counts truncated to a byte
        clear_logs();
        px[0] = 10'h3FF;
        px[1] = 10'h100;
        px[2] = 10'h2AB;
        px[3] = 10'h055;
        for (int i = 4; i < 16; i++) px[i] = 10'(i);
        pulse_start();
        for (int i = 0; i < 16; i++) push_pix(px[i]);
        wait_done();
        repeat (10) @(negedge clk);
        chk("t5_sync", got(0), 8'hA5);
        chk("t5_row0", got(1), 8'h00);
        chk("t5_trunc_ff", got(2), 8'hFF);
        chk("t5_csum0", got(6), 8'h01);
        build_exp();
        check_stream("t5");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
